// File: rtl/board_attack_arbiter.sv
// Round-robin arbiter sharing one board_attack engine between NUM_REQ requesters.
// Holds the granted board, captures the engine results and returns them over valid/ack.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module board_attack_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*`BOARD_WIDTH-1:0] req_board,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ack,
    output logic [63:0]                     rsp_white_is_attacking,
    output logic [63:0]                     rsp_black_is_attacking,
    output logic                            rsp_white_in_check,
    output logic                            rsp_black_in_check,
    output logic                            rsp_timeout,
    output logic [`BOARD_WIDTH-1:0]         atk_board,
    output logic                            atk_board_valid,
    output logic                            atk_clear,
    input  logic                            atk_done,
    input  logic [63:0]                     atk_white_is_attacking,
    input  logic [63:0]                     atk_black_is_attacking,
    input  logic                            atk_white_in_check,
    input  logic                            atk_black_in_check,
    output logic                            busy
);

    localparam int unsigned BW    = `BOARD_WIDTH;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]      board_q, board_d;
    logic [63:0]        wmap_q, wmap_d;
    logic [63:0]        bmap_q, bmap_d;
    logic               wchk_q, wchk_d;
    logic               bchk_q, bchk_d;
    logic               tout_q, tout_d;

    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   ptr_next;
    int unsigned        cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            board_q <= '0;
            wmap_q  <= '0;
            bmap_q  <= '0;
            wchk_q  <= 1'b0;
            bchk_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            board_q <= board_d;
            wmap_q  <= wmap_d;
            bmap_q  <= bmap_d;
            wchk_q  <= wchk_d;
            bchk_q  <= bchk_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        board_d   = board_q;
        wmap_d    = wmap_q;
        bmap_d    = bmap_q;
        wchk_d    = wchk_q;
        bchk_d    = bchk_q;
        tout_d    = tout_q;
        req_ready = '0;
        found     = 1'b0;
        sel       = '0;
        cand      = 0;

        // Round-robin search starting at the pointer, wrapping around.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = IDX_W'(cand);
            end
        end

        ptr_next = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready = NUM_REQ'(1) << sel;
                    board_d   = req_board[32'(sel)*BW +: BW];
                    gnt_d     = sel;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real result wins over a watchdog expiry in the same cycle.
                if (atk_done) begin
                    wmap_d  = atk_white_is_attacking;
                    bmap_d  = atk_black_is_attacking;
                    wchk_d  = atk_white_in_check;
                    bchk_d  = atk_black_in_check;
                    tout_d  = 1'b0;
                    state_d = S_CLEAR;
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    wmap_d  = '0;
                    bmap_d  = '0;
                    wchk_d  = 1'b0;
                    bchk_d  = 1'b0;
                    tout_d  = 1'b1;
                    state_d = S_CLEAR;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (rsp_ack[gnt_q]) begin
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ack[gnt_q]) begin
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign atk_board              = board_q;
    assign atk_board_valid        = (state_q == S_ISSUE);
    assign atk_clear              = (state_q == S_CLEAR);
    assign busy                   = (state_q != S_IDLE);
    assign rsp_valid              = (state_q == S_CLEAR || state_q == S_RESP) ?
                                    (NUM_REQ'(1) << gnt_q) : '0;
    assign rsp_white_is_attacking = wmap_q;
    assign rsp_black_is_attacking = bmap_q;
    assign rsp_white_in_check     = wchk_q;
    assign rsp_black_in_check     = bchk_q;
    assign rsp_timeout            = tout_q;

endmodule
